// File: rtl/display_pkg.sv
// display_pkg: constants shared by the UART message path and the LED driver.
// Contents:
// - Nibble codes for the blank and dash digit glyphs.
// - The matching 16-bit display words.
// - The FSM encoding used by uart_msg_assembler.
package display_pkg;

  // Nibble codes understood by FourDigitLEDdriver.
  localparam logic [3:0]  BLANK      = 4'hC;
  localparam logic [3:0]  DASH       = 4'hA;

  // Whole-display patterns.
  localparam logic [15:0] BLANK_WORD = {4{BLANK}};
  localparam logic [15:0] DASH_WORD  = {4{DASH}};

  // FSM encoding.
  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_WAIT_LO = 1'b1;

  typedef enum logic {
    IDLE    = ST_IDLE,
    WAIT_LO = ST_WAIT_LO
  } msg_state_e;

  // Framing and parity errors are handled identically.
  function automatic logic rx_byte_bad(input logic ferror, input logic perror);
    return ferror | perror;
  endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// rx_timeout_counter: inter-byte watchdog for uart_msg_assembler.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   clear    in   force the count to zero (has priority over enable)
//   enable   in   advance the count by one this cycle
//   terminal out  high while the count equals TIMEOUT_CYCLES-1
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owner clears the count on terminal, so it never wraps.
  assign terminal = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_msg_assembler.sv
// uart_msg_assembler: packs two UART bytes (high byte first) into the 16-bit
// word shown by FourDigitLEDdriver.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   Rx_DATA    in   received byte, qualified by Rx_VALID
//   Rx_VALID   in   one-cycle strobe per received byte
//   Rx_FERROR  in   framing error, qualified by Rx_VALID
//   Rx_PERROR  in   parity error, qualified by Rx_VALID
//   message    out  display word; nibble [15:12] is the leftmost digit
//   msg_valid  out  one-cycle pulse when message is updated
//   err_flag   out  sticky error indicator, cleared by the next good word
//   timeout    out  one-cycle pulse when a pending high byte is dropped
module uart_msg_assembler
  import display_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  Rx_DATA,
  input  logic        Rx_VALID,
  input  logic        Rx_FERROR,
  input  logic        Rx_PERROR,
  output logic [15:0] message,
  output logic        msg_valid,
  output logic        err_flag,
  output logic        timeout
);

  msg_state_e  state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] message_q, message_d;
  logic        msg_valid_q, msg_valid_d;
  logic        err_flag_q, err_flag_d;
  logic        timeout_q, timeout_d;

  logic        cnt_clear;
  logic        cnt_en;
  logic        cnt_terminal;
  logic        rx_bad;

  assign rx_bad = rx_byte_bad(Rx_FERROR, Rx_PERROR);

  rx_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_terminal)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    message_d   = message_q;
    msg_valid_d = 1'b0;
    err_flag_d  = err_flag_q;
    timeout_d   = 1'b0;
    // The counter only runs while a high byte waits with nothing arriving.
    cnt_clear   = 1'b1;
    cnt_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (Rx_VALID) begin
          if (rx_bad) begin
            message_d   = DASH_WORD;
            err_flag_d  = 1'b1;
            msg_valid_d = 1'b1;
          end else begin
            hold_d  = Rx_DATA;
            state_d = WAIT_LO;
          end
        end
      end

      WAIT_LO: begin
        // An arriving byte beats a coincident terminal count.
        if (Rx_VALID) begin
          state_d     = IDLE;
          hold_d      = '0;
          msg_valid_d = 1'b1;
          if (rx_bad) begin
            message_d  = DASH_WORD;
            err_flag_d = 1'b1;
          end else begin
            message_d  = {hold_q, Rx_DATA};
            err_flag_d = 1'b0;
          end
        end else if (cnt_terminal) begin
          timeout_d = 1'b1;
          hold_d    = '0;
          state_d   = IDLE;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      message_q   <= BLANK_WORD;
      msg_valid_q <= 1'b0;
      err_flag_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      message_q   <= message_d;
      msg_valid_q <= msg_valid_d;
      err_flag_q  <= err_flag_d;
      timeout_q   <= timeout_d;
    end
  end

  assign message   = message_q;
  assign msg_valid = msg_valid_q;
  assign err_flag  = err_flag_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_uart_msg_assembler.sv
module tb_uart_msg_assembler;
  import display_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ferror = 1'b0;
  logic        rx_perror = 1'b0;
  logic [15:0] message;
  logic        msg_valid;
  logic        err_flag;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int mv_count = 0;
  int to_count = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  uart_msg_assembler #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Rx_DATA   (rx_data),
    .Rx_VALID  (rx_valid),
    .Rx_FERROR (rx_ferror),
    .Rx_PERROR (rx_perror),
    .message   (message),
    .msg_valid (msg_valid),
    .err_flag  (err_flag),
    .timeout   (timeout)
  );

  // Behavioural model: a pending high byte is remembered with the edge index
  // at which it arrived; it expires exactly T edges later unless a byte comes.
  logic [15:0] exp_msg  = BLANK_WORD;
  logic        exp_mv   = 1'b0;
  logic        exp_err  = 1'b0;
  logic        exp_to   = 1'b0;
  bit          have_hi  = 1'b0;
  logic [7:0]  hi_byte  = 8'h00;
  int          cyc      = 0;
  int          hi_time  = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_msg <= BLANK_WORD;
      exp_mv  <= 1'b0;
      exp_err <= 1'b0;
      exp_to  <= 1'b0;
      have_hi <= 1'b0;
      hi_byte <= 8'h00;
      cyc     <= 0;
      hi_time <= 0;
    end else begin
      cyc    <= cyc + 1;
      exp_mv <= 1'b0;
      exp_to <= 1'b0;
      if (rx_valid) begin
        if (rx_ferror || rx_perror) begin
          exp_msg <= DASH_WORD;
          exp_err <= 1'b1;
          exp_mv  <= 1'b1;
          have_hi <= 1'b0;
        end else if (have_hi) begin
          exp_msg <= {hi_byte, rx_data};
          exp_err <= 1'b0;
          exp_mv  <= 1'b1;
          have_hi <= 1'b0;
        end else begin
          have_hi <= 1'b1;
          hi_byte <= rx_data;
          hi_time <= cyc;
        end
      end else if (have_hi && (cyc - hi_time) == T) begin
        exp_to  <= 1'b1;
        have_hi <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_message",   message,          exp_msg);
      check("cyc_msg_valid", {15'd0, msg_valid}, {15'd0, exp_mv});
      check("cyc_err_flag",  {15'd0, err_flag},  {15'd0, exp_err});
      check("cyc_timeout",   {15'd0, timeout},   {15'd0, exp_to});
      if (msg_valid === 1'b1) mv_count++;
      if (timeout === 1'b1) to_count++;
    end
  end

  // One call = one clock cycle of input drive, applied on the falling edge.
  task automatic cyc_drive(input bit v, input logic [7:0] d, input bit fe, input bit pe);
    @(negedge clk);
    rx_valid  = v;
    rx_data   = d;
    rx_ferror = fe;
    rx_perror = pe;
    $display("cycle t=%0t valid=%0b data=%h fe=%0b pe=%0b msg=%h mv=%0b err=%0b to=%0b",
             $time, v, d, fe, pe, message, msg_valid, err_flag, timeout);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc_drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  int mv0, to0;

  initial begin
    // Reset, then idle.
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    #2 reset = 1'b1;
    mv0 = mv_count;
    quiet(6);
    #1;
    check("reset_message", message, 16'hCCCC);
    check("reset_err", {15'd0, err_flag}, 16'd0);
    check("reset_no_mv", 16'(mv_count - mv0), 16'd0);

    // Good word, bytes five cycles apart.
    mv0 = mv_count;
    cyc_drive(1'b1, 8'hC1, 1'b0, 1'b0);
    quiet(4);
    cyc_drive(1'b1, 8'h23, 1'b0, 1'b0);
    quiet(1);
    #1;
    check("word_C123", message, 16'hC123);
    check("word_C123_mv", {15'd0, msg_valid}, 16'd1);
    quiet(3);
    check("word_C123_one_pulse", 16'(mv_count - mv0), 16'd1);
    check("word_C123_err", {15'd0, err_flag}, 16'd0);

    // Parity error on the low byte, then recovery.
    cyc_drive(1'b1, 8'hA2, 1'b0, 1'b0);
    cyc_drive(1'b1, 8'h37, 1'b0, 1'b1);
    quiet(1);
    #1;
    check("perr_dash", message, 16'hAAAA);
    check("perr_err", {15'd0, err_flag}, 16'd1);
    cyc_drive(1'b1, 8'hA8, 1'b0, 1'b0);
    cyc_drive(1'b1, 8'h88, 1'b0, 1'b0);
    quiet(1);
    #1;
    check("recover_A888", message, 16'hA888);
    check("recover_err", {15'd0, err_flag}, 16'd0);

    // Timeout: high byte then silence.
    to0 = to_count;
    cyc_drive(1'b1, 8'h12, 1'b0, 1'b0);
    quiet(10);
    check("timeout_once", 16'(to_count - to0), 16'd1);
    check("timeout_msg_kept", message, 16'hA888);
    mv0 = mv_count;
    cyc_drive(1'b1, 8'h34, 1'b0, 1'b0);
    quiet(3);
    check("after_to_no_word", 16'(mv_count - mv0), 16'd0);
    cyc_drive(1'b1, 8'h9A, 1'b0, 1'b0);
    quiet(1);
    #1;
    check("after_to_349A", message, 16'h349A);

    // Low byte on the terminal cycle wins over the timeout.
    to0 = to_count;
    cyc_drive(1'b1, 8'h12, 1'b0, 1'b0);
    quiet(T - 1);
    cyc_drive(1'b1, 8'hBC, 1'b0, 1'b0);
    quiet(3);
    check("terminal_12BC", message, 16'h12BC);
    check("terminal_no_to", 16'(to_count - to0), 16'd0);

    // Reset while a high byte is pending.
    cyc_drive(1'b1, 8'h12, 1'b0, 1'b0);
    quiet(2);
    #2 reset = 1'b0;
    #1;
    check("async_reset_blank", message, 16'hCCCC);
    quiet(2);
    #2 reset = 1'b1;
    cyc_drive(1'b1, 8'h56, 1'b0, 1'b0);
    cyc_drive(1'b1, 8'h78, 1'b0, 1'b0);
    quiet(1);
    #1;
    check("post_reset_5678", message, 16'h5678);

    // Randomized traffic: bursts, gaps around the timeout, random errors.
    for (int i = 0; i < 3000; i++) begin
      int gap_mode;
      bit v;
      gap_mode = $urandom_range(0, 3);
      if (gap_mode == 0) v = 1'b1;
      else if (gap_mode == 3) v = ($urandom_range(0, 11) == 0);
      else v = ($urandom_range(0, 3) == 0);
      cyc_drive(v, 8'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
      if (i % 1000 == 999) begin
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rand_reset_blank", message, 16'hCCCC);
        #4 reset = 1'b1;
      end
    end
    quiet(T + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
